te_commit_scheduler: RTL and testbench

//  Serialises the NRET-wide CVA6 commit stream into one trace slot per cycle for the itype detector/encoder.
//  Per-port commit info (valid, pc, branch type/taken, eret) and the exception/interrupt sidebands are packed

---
 rtl/mure_pkg.sv | 41 ++++
 rtl/te_sched_fifo.sv | 50 +++++
 rtl/te_commit_scheduler.sv | 154 +++++++++++++++
 tb/tb_te_commit_scheduler.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mure_pkg.sv
// Shared types for the trace-encoder commit scheduler.
// Slot layout, control-flow kinds and scheduler FSM states.
package mure_pkg;

    localparam int TE_XLEN = 64;

    typedef enum logic [2:0] {
        NoCF,
        Branch,
        Jump,
        JumpR,
        Return
    } cf_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } SCHED_STATE_e;

    typedef struct packed {
        logic               instr_valid;
        logic [TE_XLEN-1:0] pc;
        cf_t                cf;
        logic               taken;
        logic               eret;
        logic               ex_valid;
        logic               interrupt;
        logic               resync;
    } te_slot_t;

    function automatic logic [15:0] sat_add16(
        input logic [15:0] a,
        input logic [7:0]  b
    );
        logic [16:0] sum;
        sum = {1'b0, a} + {9'd0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/te_sched_fifo.sv
// Multi-push, single-pop slot FIFO with occupancy count.
// Head is read combinationally from registered storage.
module te_sched_fifo
    import mure_pkg::*;
#(
    parameter int NRET  = 2,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1,
    localparam int PW   = $clog2(NRET + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PW-1:0]         push_cnt,
    input  te_slot_t [NRET-1:0]   push_data,
    input  logic                  pop,
    output te_slot_t              head,
    output logic [CW-1:0]         count
);

    te_slot_t       mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    // Storage carries no reset; head is masked while empty.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NRET; i++) begin
            if (i < int'(push_cnt)) begin
                mem[wr_ptr + AW'(i)] <= push_data[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_cnt);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push_cnt) - CW'(pop);
        end
    end

    assign head = (count == '0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/te_commit_scheduler.sv
// Serialises the NRET-wide commit stream into one trace slot per cycle.
// Optional MURE_SCHED_DROP_CNT_EN adds a saturating dropped-entry counter.
module te_commit_scheduler
    import mure_pkg::*;
#(
    parameter int NRET  = 2,
    parameter int DEPTH = 8,
    parameter int XLEN  = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic [NRET-1:0]      commit_valid_i,
    input  logic [NRET*XLEN-1:0] commit_pc_i,
    input  cf_t [NRET-1:0]       branch_type_i,
    input  logic [NRET-1:0]      branch_taken_i,
    input  logic [NRET-1:0]      eret_i,
    input  logic                 commit_ex_valid_i,
    input  logic                 interrupt_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output te_slot_t             out_entry_o,
    output logic                 overflow_o,
`ifdef MURE_SCHED_DROP_CNT_EN
    output logic [15:0]          drop_cnt_o,
`endif
    output logic                 busy_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(NRET + 1);

    SCHED_STATE_e          state;
    logic                  resync_q;
    te_slot_t [NRET-1:0]   cand;
    logic [PW-1:0]         n_cand;
    logic [PW-1:0]         n_acc;
    logic [CW-1:0]         count;
    logic [CW-1:0]         free;
    logic                  side;
    logic                  run;
    logic                  pop;
    logic                  drop;

    assign side = commit_ex_valid_i | interrupt_i;
    assign run  = (state == RUN);
    assign free = CW'(DEPTH) - count;

    // Compact valid ports oldest-first; sidebands ride on port 0.
    always_comb begin
        cand   = '0;
        n_cand = '0;
        for (int i = 0; i < NRET; i++) begin
            if (commit_valid_i[i] || (i == 0 && side)) begin
                cand[n_cand].instr_valid = commit_valid_i[i];
                cand[n_cand].pc    = TE_XLEN'(commit_pc_i[i*XLEN +: XLEN]);
                cand[n_cand].cf    = branch_type_i[i];
                cand[n_cand].taken = branch_taken_i[i];
                cand[n_cand].eret  = eret_i[i];
                if (i == 0) begin
                    cand[n_cand].ex_valid  = commit_ex_valid_i;
                    cand[n_cand].interrupt = interrupt_i;
                end
                n_cand = n_cand + PW'(1);
            end
        end
        if (!run) begin
            n_cand = '0;
        end
        cand[0].resync = resync_q;
    end

    assign drop  = CW'(n_cand) > free;
    assign n_acc = drop ? PW'(free) : n_cand;
    assign pop   = out_valid_o & out_ready_i & (state != IDLE);

    te_sched_fifo #(
        .NRET  (NRET),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push_cnt  (n_acc),
        .push_data (cand),
        .pop       (pop),
        .head      (out_entry_o),
        .count     (count)
    );

    assign out_valid_o = (count != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            busy_o     <= 1'b0;
            overflow_o <= 1'b0;
            resync_q   <= 1'b0;
        end else begin
            overflow_o <= drop;
            // A drop re-arms resync even if an older entry took it now.
            if (drop) begin
                resync_q <= 1'b1;
            end else if (n_acc != '0) begin
                resync_q <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (enable_i) begin
                        state  <= RUN;
                        busy_o <= 1'b1;
                    end
                end
                RUN: begin
                    if (!enable_i) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (enable_i) begin
                        state <= RUN;
                    end else if (count == '0) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef MURE_SCHED_DROP_CNT_EN
    logic [PW-1:0] n_drop;
    logic [15:0]   drop_cnt;

    assign n_drop = n_cand - n_acc;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drop_cnt <= '0;
        end else if (state == IDLE && enable_i) begin
            drop_cnt <= '0;
        end else if (drop) begin
            drop_cnt <= sat_add16(drop_cnt, 8'(n_drop));
        end
    end

    assign drop_cnt_o = drop_cnt;
`endif

endmodule

// File: tb/tb_te_commit_scheduler.sv
// Directed bench for te_commit_scheduler (NRET=2, DEPTH=8).
// Walks fill, overflow/resync, sidebands, drain and async reset.
module tb_te_commit_scheduler;
    import mure_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [1:0]    cv = '0;
    logic [127:0]  pcs = '0;
    cf_t [1:0]     bt;
    logic [1:0]    tk = '0;
    logic [1:0]    er = '0;
    logic          ex = 1'b0;
    logic          irq = 1'b0;
    logic          ov;
    logic          rdy = 1'b0;
    te_slot_t      ent;
    logic          ovf;
    logic          busy;
`ifdef MURE_SCHED_DROP_CNT_EN
    logic [15:0]   dcnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    te_commit_scheduler dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .enable_i          (enable),
        .commit_valid_i    (cv),
        .commit_pc_i       (pcs),
        .branch_type_i     (bt),
        .branch_taken_i    (tk),
        .eret_i            (er),
        .commit_ex_valid_i (ex),
        .interrupt_i       (irq),
        .out_valid_o       (ov),
        .out_ready_i       (rdy),
        .out_entry_o       (ent),
        .overflow_o        (ovf),
`ifdef MURE_SCHED_DROP_CNT_EN
        .drop_cnt_o        (dcnt),
`endif
        .busy_o            (busy)
    );

    function automatic te_slot_t mk(
        input logic        iv,
        input logic [63:0] pc,
        input cf_t         cf,
        input logic        t,
        input logic        e,
        input logic        x,
        input logic        i,
        input logic        rs
    );
        te_slot_t s;
        s.instr_valid = iv;
        s.pc          = pc;
        s.cf          = cf;
        s.taken       = t;
        s.eret        = e;
        s.ex_valid    = x;
        s.interrupt   = i;
        s.resync      = rs;
        return s;
    endfunction

    function automatic te_slot_t ins(
        input logic [63:0] pc,
        input logic        rs
    );
        return mk(1'b1, pc, NoCF, 1'b0, 1'b0, 1'b0, 1'b0, rs);
    endfunction

    task automatic chk_bit(
        input string tag,
        input logic  obs,
        input logic  exp
    );
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_ent(
        input string    tag,
        input te_slot_t obs,
        input te_slot_t exp
    );
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drv(
        input logic [1:0]  v,
        input logic [63:0] p0,
        input logic [63:0] p1
    );
        cv  = v;
        pcs = {p1, p0};
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bt[0] = NoCF;
        bt[1] = NoCF;
        repeat (2) @(posedge clk);
        #1;
        chk_bit("rst_valid", ov, 1'b0);
        chk_ent("rst_entry", ent, '0);
        chk_bit("rst_ovf", ovf, 1'b0);
        chk_bit("rst_busy", busy, 1'b0);
        rst    = 1'b0;
        enable = 1'b1;
        tick;
        chk_bit("run_busy", busy, 1'b1);

        // Fill: two pushes, one pop per cycle until full.
        rdy = 1'b1;
        for (int k = 0; k < 7; k++) begin
            drv(2'b11, 64'h100 + 64'(8 * k), 64'h104 + 64'(8 * k));
            tick;
            chk_bit("t1_valid", ov, 1'b1);
            chk_ent("t1_head", ent, ins(64'h100 + 64'(4 * k), 1'b0));
            chk_bit("t1_ovf", ovf, k == 6);
        end

        // Seven held, ready low: port 0 in, port 1 dropped.
        rdy = 1'b0;
        drv(2'b11, 64'h200, 64'h204);
        tick;
        chk_bit("t2_ovf", ovf, 1'b1);
        chk_ent("t2_hold", ent, ins(64'h118, 1'b0));
        drv(2'b00, 64'h0, 64'h0);
        tick;
        chk_bit("t2_ovf_pulse", ovf, 1'b0);
        chk_ent("t2_stable", ent, ins(64'h118, 1'b0));
        drv(2'b01, 64'h300, 64'h0);
        tick;
        chk_bit("t2_full_drop", ovf, 1'b1);
        drv(2'b00, 64'h0, 64'h0);
        rdy = 1'b1;
        for (int j = 0; j < 7; j++) begin
            tick;
            if (j < 6) begin
                chk_ent("t2_drain", ent, ins(64'h11C + 64'(4 * j), 1'b0));
            end else begin
                chk_ent("t2_resync", ent, ins(64'h200, 1'b1));
            end
        end
        tick;
        chk_bit("t2_empty", ov, 1'b0);
        chk_ent("t2_empty_ent", ent, '0);

        // Push and pop requested on empty: no bypass.
        drv(2'b01, 64'h400, 64'h0);
        tick;
        chk_ent("nobypass", ent, ins(64'h400, 1'b1));
        drv(2'b01, 64'h404, 64'h0);
        tick;
        chk_ent("resync_clr", ent, ins(64'h404, 1'b0));
        drv(2'b00, 64'h0, 64'h0);
        tick;
        chk_bit("empty2", ov, 1'b0);

        // Interrupt without a commit: pseudo-entry.
        rdy = 1'b0;
        irq = 1'b1;
        tick;
        irq = 1'b0;
        chk_ent("t3_irq", ent,
                mk(1'b0, 64'h0, NoCF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));

        // Exception on a branch commit.
        ex    = 1'b1;
        bt[0] = Branch;
        tk    = 2'b01;
        drv(2'b01, 64'h600, 64'h0);
        tick;
        ex    = 1'b0;
        bt[0] = NoCF;
        tk    = 2'b00;
        drv(2'b00, 64'h0, 64'h0);
        chk_bit("t3_ovf", ovf, 1'b0);
        rdy = 1'b1;
        tick;
        chk_ent("t4_ex", ent,
                mk(1'b1, 64'h600, Branch, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));

        // Port 1 only: compacted into slot 0.
        er = 2'b10;
        drv(2'b10, 64'h0, 64'h704);
        tick;
        er = 2'b00;
        drv(2'b00, 64'h0, 64'h0);
        chk_ent("compact", ent,
                mk(1'b1, 64'h704, NoCF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        tick;
        chk_bit("empty3", ov, 1'b0);

        // Drain with four queued.
        rdy = 1'b0;
        drv(2'b11, 64'h800, 64'h804);
        tick;
        drv(2'b11, 64'h808, 64'h80C);
        tick;
        drv(2'b00, 64'h0, 64'h0);
        enable = 1'b0;
        rdy    = 1'b1;
        tick;
        chk_ent("t5_d1", ent, ins(64'h804, 1'b0));
        chk_bit("t5_busy1", busy, 1'b1);
        drv(2'b11, 64'h900, 64'h904);
        tick;
        chk_ent("t5_d2", ent, ins(64'h808, 1'b0));
        tick;
        chk_ent("t5_d3", ent, ins(64'h80C, 1'b0));
        tick;
        chk_bit("t5_empty", ov, 1'b0);
        chk_bit("t5_busy2", busy, 1'b1);
        tick;
        chk_bit("t5_idle", busy, 1'b0);
        chk_bit("t5_ignored", ov, 1'b0);
        tick;
        chk_bit("t5_idle_disc", ov, 1'b0);
        drv(2'b00, 64'h0, 64'h0);

        // Async reset with five queued.
        enable = 1'b1;
        tick;
        rdy = 1'b0;
        drv(2'b11, 64'hA00, 64'hA04);
        tick;
        drv(2'b11, 64'hA08, 64'hA0C);
        tick;
        drv(2'b01, 64'hA10, 64'h0);
        tick;
        drv(2'b00, 64'h0, 64'h0);
        chk_bit("t6_valid", ov, 1'b1);
        chk_ent("t6_head", ent, ins(64'hA00, 1'b0));
        rst = 1'b1;
        #1;
        chk_bit("t6_rst_valid", ov, 1'b0);
        chk_ent("t6_rst_ent", ent, '0);
        chk_bit("t6_rst_busy", busy, 1'b0);
        tick;
        rst    = 1'b0;
        enable = 1'b0;
        tick;
        chk_bit("t6_post_valid", ov, 1'b0);
        chk_bit("t6_post_busy", busy, 1'b0);
        enable = 1'b1;
        tick;
        chk_bit("t6_rerun", busy, 1'b1);
        drv(2'b01, 64'hB00, 64'h0);
        tick;
        drv(2'b00, 64'h0, 64'h0);
        chk_ent("t6_fresh", ent, ins(64'hB00, 1'b0));
        tick;
        chk_ent("t6_hold", ent, ins(64'hB00, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
